// File: rtl/swn_pkg.sv
// swn_pkg: shared types, default parameters and the window negation helper
// for serial_window_negator.
package swn_pkg;

  // Default geometry of the block.
  localparam int SWN_DEPTH_DEFAULT = 16;
  localparam int SWN_WIN_DEFAULT   = 3;

  // Widest window the negation helper supports.
  localparam int SWN_WIN_MAX = 32;

  // Fill state of the shift register.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } swn_state_e;

  // Two's-complement negation of a zero-extended window. The low WIN bits
  // of the result equal (0 - window) mod 2^WIN for any WIN <= SWN_WIN_MAX.
  function automatic logic [SWN_WIN_MAX-1:0] swn_negate(input logic [SWN_WIN_MAX-1:0] value);
    return {SWN_WIN_MAX{1'b0}} - value;
  endfunction

endpackage

// File: rtl/swn_bit_counter.sv
// swn_bit_counter: wrapping frame bit counter and saturating fill counter.
// clr has priority over shift_en; frame_done flags the edge that accepts the
// last bit of a frame.
module swn_bit_counter
  import swn_pkg::*;
#(
  parameter int DEPTH = SWN_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       shift_en,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
  output logic                       frame_done
);

  localparam int CW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] BIT_LAST = CW'(DEPTH - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

  logic [CW-1:0] bit_cnt_r;
  logic [FW-1:0] fill_cnt_r;

  // Bit position within the current frame; wraps to zero after the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      bit_cnt_r <= {CW{1'b0}};
    end else if (shift_en) begin
      if (bit_cnt_r == BIT_LAST) begin
        bit_cnt_r <= {CW{1'b0}};
      end else begin
        bit_cnt_r <= bit_cnt_r + CW'(1);
      end
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // Number of accepted bits since reset or clr, saturating at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_r <= {FW{1'b0}};
    end else if (clr) begin
      fill_cnt_r <= {FW{1'b0}};
    end else if (shift_en && (fill_cnt_r != FILL_MAX)) begin
      fill_cnt_r <= fill_cnt_r + FW'(1);
    end else begin
      fill_cnt_r <= fill_cnt_r;
    end
  end

  assign fill_cnt   = fill_cnt_r;
  assign frame_done = shift_en & ~clr & (bit_cnt_r == BIT_LAST);

endmodule

// File: rtl/serial_window_negator.sv
// serial_window_negator: serial-in shift register with a negated low window
// and framed parallel output.
// Optional feature macro: SWN_MATCH_EN adds a registered frame comparator
// against match_pattern; without it match is tied low.
module serial_window_negator
  import swn_pkg::*;
#(
  parameter int DEPTH = SWN_DEPTH_DEFAULT,
  parameter int WIN   = SWN_WIN_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       shift_en,
  input  logic                       data_in,
  input  logic                       clr,
  input  logic [DEPTH-1:0]           match_pattern,
  output logic [WIN-1:0]             data_out,
  output logic                       win_valid,
  output logic [DEPTH-1:0]           frame_out,
  output logic                       frame_valid,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt,
  output logic                       match
);

  localparam int FW = $clog2(DEPTH + 1);

  localparam logic [FW-1:0] FILL_LAST = FW'(DEPTH - 1);
  localparam logic [FW-1:0] WIN_FILL  = FW'(WIN);

  logic [DEPTH-1:0] sr_r;
  logic [DEPTH-1:0] sr_next_s;
  logic [DEPTH-1:0] frame_r;
  logic             frame_valid_r;
  logic             accept_s;
  logic             frame_done_s;
  logic [FW-1:0]    fill_cnt_s;
  swn_state_e       state_r;

  assign accept_s  = shift_en & ~clr;
  assign sr_next_s = {sr_r[DEPTH-2:0], data_in};

  swn_bit_counter #(
    .DEPTH (DEPTH)
  ) u_bit_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .shift_en   (shift_en),
    .fill_cnt   (fill_cnt_s),
    .frame_done (frame_done_s)
  );

  // Serial shift register; newest bit enters at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r <= {DEPTH{1'b0}};
    end else if (clr) begin
      sr_r <= {DEPTH{1'b0}};
    end else if (accept_s) begin
      sr_r <= sr_next_s;
    end else begin
      sr_r <= sr_r;
    end
  end

  // Fill state machine: EMPTY -> FILLING -> FULL, clr returns to EMPTY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (clr) begin
            state_r <= EMPTY;
          end else if (accept_s) begin
            state_r <= FILLING;
          end else begin
            state_r <= EMPTY;
          end
        end
        FILLING: begin
          if (clr) begin
            state_r <= EMPTY;
          end else if (accept_s && (fill_cnt_s == FILL_LAST)) begin
            state_r <= FULL;
          end else begin
            state_r <= FILLING;
          end
        end
        FULL: begin
          if (clr) begin
            state_r <= EMPTY;
          end else begin
            state_r <= FULL;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

  // Frame capture and one-cycle valid pulse on the frame-completing edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_r       <= {DEPTH{1'b0}};
      frame_valid_r <= 1'b0;
    end else if (frame_done_s) begin
      frame_r       <= sr_next_s;
      frame_valid_r <= 1'b1;
    end else begin
      frame_r       <= frame_r;
      frame_valid_r <= 1'b0;
    end
  end

`ifdef SWN_MATCH_EN
  logic match_r;
  logic unused_s;

  // Registered comparison of the completing frame against match_pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_r <= 1'b0;
    end else if (frame_done_s) begin
      match_r <= (sr_next_s == match_pattern);
    end else begin
      match_r <= 1'b0;
    end
  end

  // The oldest register bit only falls off the end of the shift.
  assign unused_s = sr_r[DEPTH-1];
  assign match    = match_r;
`else
  logic unused_s;

  // No comparator: the pattern and the shifted-out bit are sinks only.
  assign unused_s = ^{sr_r[DEPTH-1], match_pattern};
  assign match    = 1'b0;
`endif

  assign data_out    = WIN'(swn_negate(SWN_WIN_MAX'(sr_r[WIN-1:0])));
  assign win_valid   = (fill_cnt_s >= WIN_FILL);
  assign frame_out   = frame_r;
  assign frame_valid = frame_valid_r;
  assign fill_cnt    = fill_cnt_s;

endmodule

// File: tb/tb_serial_window_negator.sv
// tb_serial_window_negator: directed self-checking bench for
// serial_window_negator at DEPTH=16, WIN=3.
module tb_serial_window_negator;
  import swn_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        shift_en;
  logic        data_in;
  logic        clr;
  logic [15:0] match_pattern;
  logic [2:0]  data_out;
  logic        win_valid;
  logic [15:0] frame_out;
  logic        frame_valid;
  logic [4:0]  fill_cnt;
  logic        match;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int fv_cycles[$];
  int match_cycles[$];
  logic [15:0] frames[$];

  serial_window_negator #(
    .DEPTH (16),
    .WIN   (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .shift_en      (shift_en),
    .data_in       (data_in),
    .clr           (clr),
    .match_pattern (match_pattern),
    .data_out      (data_out),
    .win_valid     (win_valid),
    .frame_out     (frame_out),
    .frame_valid   (frame_valid),
    .fill_cnt      (fill_cnt),
    .match         (match)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply inputs across one rising edge; return at the following falling edge
  // and log any frame/match pulse seen there.
  task automatic drive(input logic en, input logic d, input logic c);
    shift_en = en;
    data_in  = d;
    clr      = c;
    @(negedge clk);
    cyc++;
    if (frame_valid === 1'b1) begin
      fv_cycles.push_back(cyc);
      frames.push_back(frame_out);
    end
    if (match === 1'b1) begin
      match_cycles.push_back(cyc);
    end
  endtask

  // Send a 16-bit word MSB first; gap_mod > 0 inserts an idle cycle after
  // every bit whose index is a multiple of gap_mod.
  task automatic send_word(input logic [15:0] w, input int gap_mod);
    for (int i = 15; i >= 0; i--) begin
      drive(1'b1, w[i], 1'b0);
      if ((gap_mod > 0) && ((i % gap_mod) == 0) && (i != 0)) begin
        drive(1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    int n0;
    int m0;
    rst_n         = 1'b0;
    shift_en      = 1'b0;
    data_in       = 1'b0;
    clr           = 1'b0;
    match_pattern = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);

    // Reset state.
    chk("rst_data_out",    32'(data_out),    32'd0);
    chk("rst_win_valid",   32'(win_valid),   32'd0);
    chk("rst_fill_cnt",    32'(fill_cnt),    32'd0);
    chk("rst_frame_out",   32'(frame_out),   32'd0);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_match",       32'(match),       32'd0);
    chk("rst_state",       32'(dut.state_r), 32'(EMPTY));
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // Single 1 bit: window 001 -> 7.
    drive(1'b1, 1'b1, 1'b0);
    chk("one_data_out",  32'(data_out),  32'd7);
    chk("one_win_valid", 32'(win_valid), 32'd0);
    chk("one_fill_cnt",  32'(fill_cnt),  32'd1);

    // Bits 1,0,0 from a cleared register: 7, 6, then 4 with win_valid.
    drive(1'b0, 1'b0, 1'b1);
    chk("clr0_data_out", 32'(data_out), 32'd0);
    drive(1'b1, 1'b1, 1'b0);
    chk("w1_data_out", 32'(data_out), 32'd7);
    drive(1'b1, 1'b0, 1'b0);
    chk("w2_data_out",  32'(data_out),  32'd6);
    chk("w2_win_valid", 32'(win_valid), 32'd0);
    drive(1'b1, 1'b0, 1'b0);
    chk("w3_data_out",  32'(data_out),  32'd4);
    chk("w3_win_valid", 32'(win_valid), 32'd1);
    chk("w3_fill_cnt",  32'(fill_cnt),  32'd3);

    // 0xA5C3 with idle gaps: exactly one frame after the 16th bit.
    drive(1'b0, 1'b0, 1'b1);
    n0 = fv_cycles.size();
    send_word(16'hA5C3, 3);
    chk("a5_frame_valid", 32'(frame_valid), 32'd1);
    chk("a5_frame_out",   32'(frame_out),   32'hA5C3);
    chk("a5_data_out",    32'(data_out),    32'd5);
    chk("a5_fill_cnt",    32'(fill_cnt),    32'd16);
    chk("a5_state",       32'(dut.state_r), 32'(FULL));
    drive(1'b0, 1'b0, 1'b0);
    chk("a5_fv_drop",  32'(frame_valid),             32'd0);
    chk("a5_n_frames", 32'(fv_cycles.size() - n0),   32'd1);

    // Back-to-back frames 0x1234 and 0xFFFF.
    drive(1'b0, 1'b0, 1'b1);
    n0 = fv_cycles.size();
    send_word(16'h1234, 0);
    send_word(16'hFFFF, 0);
    chk("b2b_n_frames", 32'(fv_cycles.size() - n0), 32'd2);
    if (fv_cycles.size() - n0 == 2) begin
      chk("b2b_spacing", 32'(fv_cycles[n0+1] - fv_cycles[n0]), 32'd16);
      chk("b2b_frame0",  32'(frames[n0]),                      32'h1234);
      chk("b2b_frame1",  32'(frames[n0+1]),                    32'hFFFF);
    end
    chk("b2b_data_out", 32'(data_out), 32'd1);
    chk("b2b_fill_cnt", 32'(fill_cnt), 32'd16);

    // clr together with shift_en after 10 bits.
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0);
    end
    chk("pre_clr_fill_cnt", 32'(fill_cnt), 32'd10);
    n0 = fv_cycles.size();
    drive(1'b1, 1'b1, 1'b1);
    chk("clr_fill_cnt",    32'(fill_cnt),    32'd0);
    chk("clr_win_valid",   32'(win_valid),   32'd0);
    chk("clr_data_out",    32'(data_out),    32'd0);
    chk("clr_frame_out",   32'(frame_out),   32'hFFFF);
    chk("clr_frame_valid", 32'(frame_valid), 32'd0);
    chk("clr_state",       32'(dut.state_r), 32'(EMPTY));
    for (int i = 15; i >= 1; i--) begin
      drive(1'b1, (16'h0F0F >> i) & 16'h1, 1'b0);
    end
    chk("clr_no_early_frame", 32'(fv_cycles.size() - n0), 32'd0);
    drive(1'b1, 1'b1, 1'b0);
    chk("clr_frame_valid2", 32'(frame_valid), 32'd1);
    chk("clr_frame_out2",   32'(frame_out),   32'h0F0F);

    // Reset mid-stream: the partial frame is lost.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0);
    end
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    chk("mid_rst_fill_cnt",  32'(fill_cnt),  32'd0);
    chk("mid_rst_frame_out", 32'(frame_out), 32'd0);
    rst_n = 1'b1;
    n0 = fv_cycles.size();
    send_word(16'h5A5A, 0);
    chk("mid_rst_n_frames",  32'(fv_cycles.size() - n0), 32'd1);
    chk("mid_rst_frame_out", 32'(frame_out),             32'h5A5A);
    chk("mid_rst_data_out",  32'(data_out),              32'd6);

    // Pattern match: 0xBEEF then 0xBEEE.
    drive(1'b0, 1'b0, 1'b1);
    n0 = fv_cycles.size();
    m0 = match_cycles.size();
    send_word(16'hBEEF, 0);
    send_word(16'hBEEE, 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("pat_n_frames", 32'(fv_cycles.size() - n0), 32'd2);
`ifdef SWN_MATCH_EN
    chk("pat_n_match", 32'(match_cycles.size() - m0), 32'd1);
    if ((match_cycles.size() - m0 == 1) && (fv_cycles.size() - n0 >= 1)) begin
      chk("pat_match_cycle", 32'(match_cycles[m0]), 32'(fv_cycles[n0]));
    end
`else
    chk("pat_n_match", 32'(match_cycles.size()), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_window_negator.md
# serial_window_negator

Parametrised serial-in shift register with a decoded output window. Each accepted serial bit shifts into a DEPTH-bit register. The low WIN bits are presented as their two's-complement negation modulo 2^WIN. Every DEPTH accepted bits, the block emits a complete frame with a one-cycle valid pulse. It sits directly behind the serial input pin logic and feeds downstream decode and display stages.

## Interface
- DEPTH, 16: shift register length and frame size in bits; must be at least 2.
- WIN, 3: output window width; must satisfy 1 <= WIN <= DEPTH.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- shift_en  in  1  accept data_in this cycle.
- data_in  in  1  serial input bit.
- clr  in  1  synchronous clear of the register, counters and state.
- match_pattern  in  DEPTH  compare value; used only when the match feature is compiled in.
- data_out  out  WIN  (0 - sr[WIN-1:0]) mod 2^WIN, combinational from the register.
- win_valid  out  1  at least WIN bits accepted since the last reset or clr.
- frame_out  out  DEPTH  last complete frame; the first-received bit is the MSB.
- frame_valid  out  1  one-cycle pulse when frame_out is updated.
- fill_cnt  out  $clog2(DEPTH+1)  number of accepted bits, saturating at DEPTH.
- match  out  1  one-cycle pulse when a completed frame equals match_pattern.

## Operation
- Shift: when shift_en=1 and clr=0, sr <= {sr[DEPTH-2:0], data_in}.
- When shift_en=0, sr holds.
- Negation examples at WIN=3: window 0 gives 0, 1 gives 7, 4 gives 4, 7 gives 1.
- State machine (state register plus bit_cnt):
  - EMPTY: fill_cnt=0. An accepted bit moves to FILLING.
  - FILLING: the accepted bit that makes fill_cnt reach DEPTH moves to FULL.
  - FULL: stays in FULL until clr or reset.
  - clr from any state moves to EMPTY.
- win_valid = (fill_cnt >= WIN).
- bit_cnt counts 0..DEPTH-1 and wraps to 0 on the DEPTH-th accepted bit. At that edge:
  - frame_out <= the new register value, {sr[DEPTH-2:0], data_in}.
  - frame_valid=1 for the following cycle only.
- Frames are non-overlapping. After the first frame, every further DEPTH accepted bits produce another frame.
- clr and shift_en high together: clr wins and the bit is discarded. sr, bit_cnt, fill_cnt and win_valid go to 0. frame_out keeps its value. frame_valid and match are 0 in the next cycle.
- Gaps in shift_en do not reset the counters; frames span gaps.

## Timing
- Reset values: sr=0, state=EMPTY, bit_cnt=0, fill_cnt=0, frame_out=0, frame_valid=0, match=0, win_valid=0, data_out=0.
- data_out: zero latency from the register; it reflects the bit accepted at edge N during the cycle after edge N.
- frame_valid and match: registered; asserted in the cycle after the completing edge, deasserted one cycle later unless another frame completes.
- rst_n deassertion mid-stream: the partial frame is lost and counting restarts from 0 on the next accepted bit.
- Sustained throughput: one bit per cycle, with no dead cycle between frames.

## Configuration
- SWN_MATCH_EN defined:
  - A registered comparator evaluates the completing frame, {sr[DEPTH-2:0], data_in}, against match_pattern at the wrap edge.
  - match pulses coincident with frame_valid when they are equal.
- SWN_MATCH_EN undefined:
  - match is tied to 0, match_pattern is unused, and no comparator logic is generated.

## Structure
- Package swn_pkg holds:
  - the state enum (EMPTY, FILLING, FULL);
  - a function negating a WIN-bit vector;
  - default parameter constants.
- One sub-module, swn_bit_counter, holds the wrapping bit_cnt and saturating fill_cnt with the clr/enable priority, and produces the frame-complete strobe.
- The top level holds the shift register, state machine, frame register and optional comparator.

## Test plan
- Reset, then shift_en=1 with data_in=1 for one bit -> data_out=7; win_valid=0 until 3 bits accepted; fill_cnt=1.
- Shift bits 1,0,0 (DEPTH=16, WIN=3) -> window 3'b100, data_out=4, win_valid=1 after the 3rd edge.
- Shift 16 bits of 0xA5C3, MSB first, with random shift_en gaps -> frame_valid pulses once after the 16th accepted bit; frame_out=0xA5C3; state=FULL.
- Continuous shifting of 32 bits, 0x1234 then 0xFFFF -> two frame_valid pulses exactly 16 cycles apart; frame_out=0x1234, then 0xFFFF.
- After 10 bits, assert clr together with shift_en -> fill_cnt=0, win_valid=0, data_out=0, frame_out unchanged; the next frame needs 16 fresh bits.
- With SWN_MATCH_EN and match_pattern=0xBEEF, send 0xBEEF then 0xBEEE -> match pulses with the first frame_valid only; without the macro, match stays 0.
